// File: rtl/gif_sequencer_if.sv
// rtl/gif_sequencer_if.sv - key inputs and frame outputs of the GIF frame sequencer
interface gif_sequencer_if #(
    parameter int FRAMES = 8,
    parameter int IDX_W  = 3
);
    logic              en;
    logic              next_short;
    logic              next_long;
    logic              prev_short;
    logic              prev_long;
    logic [IDX_W-1:0]  frame_idx;
    logic [FRAMES-1:0] frame_en;
    logic              running;
    logic              mode;
    logic [1:0]        speed;
    logic              frame_tick;

    modport master (
        output en, next_short, next_long, prev_short, prev_long,
        input  frame_idx, frame_en, running, mode, speed, frame_tick
    );

    modport slave (
        input  en, next_short, next_long, prev_short, prev_long,
        output frame_idx, frame_en, running, mode, speed, frame_tick
    );
endinterface

// File: rtl/gif_sequencer.sv
// rtl/gif_sequencer.sv - manual/auto frame sequencer with loop and ping-pong playback
module gif_sequencer #(
    parameter int FRAMES   = 8,
    parameter int IDX_W    = 3,
    parameter int BASE_DIV = 4194304
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    gif_sequencer_if.slave bus
);
    localparam int TMR_W = $clog2(BASE_DIV);

    typedef enum logic {MANUAL = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [TMR_W-1:0]  timer_q, timer_n;
    logic [1:0]        speed_q, speed_n;
    logic              mode_q, mode_n;
    logic              dir_up_q, dir_up_n;
    logic              tick_q, tick_n;

    logic [31:0]       period_m1;
    logic              at_last, at_first, wrap;
    logic [IDX_W-1:0]  idx_inc, idx_dec;
    logic              only_next, only_prev;

    assign period_m1 = (32'(BASE_DIV) >> speed_q) - 32'd1;
    assign wrap      = (timer_q == period_m1[TMR_W-1:0]);
    assign at_last   = (idx_q == IDX_W'(FRAMES - 1));
    assign at_first  = (idx_q == '0);
    assign idx_inc   = at_last  ? '0 : idx_q + 1'b1;
    assign idx_dec   = at_first ? IDX_W'(FRAMES - 1) : idx_q - 1'b1;
    assign only_next = bus.next_short & ~bus.prev_short;
    assign only_prev = bus.prev_short & ~bus.next_short;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= MANUAL;
            idx_q    <= '0;
            timer_q  <= '0;
            speed_q  <= 2'd0;
            mode_q   <= 1'b0;
            dir_up_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            timer_q  <= timer_n;
            speed_q  <= speed_n;
            mode_q   <= mode_n;
            dir_up_q <= dir_up_n;
            tick_q   <= tick_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        timer_n  = timer_q;
        speed_n  = speed_q;
        mode_n   = mode_q;
        dir_up_n = dir_up_q;
        tick_n   = 1'b0;

        if (!bus.en) begin
            state_n  = MANUAL;
            timer_n  = '0;
            dir_up_n = 1'b1;
        end else begin
            case (state_q)
                MANUAL: begin
                    timer_n = '0;
                    if (bus.prev_long) begin
                        idx_n = '0;
                    end else if (bus.next_long) begin
                        state_n = RUN;
                    end else if (only_next) begin
                        idx_n = idx_inc;
                    end else if (only_prev) begin
                        idx_n = idx_dec;
                    end
                end
                RUN: begin
                    if (bus.prev_long) begin
                        state_n  = MANUAL;
                        idx_n    = '0;
                        dir_up_n = 1'b1;
                        timer_n  = '0;
                    end else if (bus.next_long) begin
                        mode_n   = ~mode_q;
                        dir_up_n = 1'b1;
                        timer_n  = '0;
                    end else if (only_next) begin
                        speed_n = (speed_q == 2'd3) ? 2'd3 : speed_q + 2'd1;
                        timer_n = '0;
                    end else if (only_prev) begin
                        speed_n = (speed_q == 2'd0) ? 2'd0 : speed_q - 2'd1;
                        timer_n = '0;
                    end else if (wrap) begin
                        timer_n = '0;
                        tick_n  = 1'b1;
                        if (!mode_q) begin
                            idx_n = idx_inc;
                        end else if (dir_up_q) begin
                            // Turn around at the top without repeating the end frame
                            if (at_last) begin
                                idx_n    = idx_dec;
                                dir_up_n = 1'b0;
                            end else begin
                                idx_n = idx_inc;
                            end
                        end else begin
                            if (at_first) begin
                                idx_n    = idx_inc;
                                dir_up_n = 1'b1;
                            end else begin
                                idx_n = idx_dec;
                            end
                        end
                    end else begin
                        timer_n = timer_q + 1'b1;
                    end
                end
                default: state_n = MANUAL;
            endcase
        end
    end

    always_comb begin
        bus.frame_en = '0;
        for (int i = 0; i < FRAMES; i++) begin
            bus.frame_en[i] = bus.en && (idx_q == IDX_W'(i));
        end
    end

    assign bus.frame_idx  = idx_q;
    assign bus.running    = (state_q == RUN);
    assign bus.mode       = mode_q;
    assign bus.speed      = speed_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_gif_sequencer.sv
// tb/tb_gif_sequencer.sv - directed self-checking bench for gif_sequencer
module tb_gif_sequencer;
    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cnt;
    int   ticks;

    gif_sequencer_if #(.FRAMES(5), .IDX_W(3)) bus ();

    gif_sequencer #(.FRAMES(5), .IDX_W(3), .BASE_DIV(16)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = {prev_long, next_long, prev_short, next_short}, held for one edge
    task automatic press(input logic [3:0] k);
        {bus.prev_long, bus.next_long, bus.prev_short, bus.next_short} = k;
        step();
        {bus.prev_long, bus.next_long, bus.prev_short, bus.next_short} = 4'b0000;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_tick && n < 100);
    endtask

    initial begin
        int loop_seq[5] = '{1, 2, 3, 4, 0};
        int pp_seq[9]   = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

        bus.en = 1'b1;
        {bus.prev_long, bus.next_long, bus.prev_short, bus.next_short} = 4'b0000;
        rst = 1'b1;
        step();
        step();
        chk("rst_idx", 32'(bus.frame_idx), 0);
        chk("rst_frame_en", 32'(bus.frame_en), 32'b00001);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_speed", 32'(bus.speed), 0);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        rst = 1'b0;
        step();

        press(4'b0010);
        chk("prev_wrap_idx", 32'(bus.frame_idx), 4);
        chk("prev_wrap_en", 32'(bus.frame_en), 32'b10000);
        press(4'b0001);
        chk("next_wrap_idx", 32'(bus.frame_idx), 0);
        press(4'b0011);
        chk("both_short_idx", 32'(bus.frame_idx), 0);
        press(4'b0001);
        press(4'b0001);
        chk("next_twice_idx", 32'(bus.frame_idx), 2);
        press(4'b1001);
        chk("manual_prev_long_idx", 32'(bus.frame_idx), 0);
        chk("manual_prev_long_run", 32'(bus.running), 0);

        press(4'b0100);
        chk("run_entry", 32'(bus.running), 1);
        chk("run_entry_idx", 32'(bus.frame_idx), 0);
        for (int i = 0; i < 5; i++) begin
            wait_tick(cnt);
            chk($sformatf("loop_period_%0d", i), 32'(cnt), 16);
            chk($sformatf("loop_idx_%0d", i), 32'(bus.frame_idx), 32'(loop_seq[i]));
        end

        press(4'b0100);
        chk("pp_mode", 32'(bus.mode), 1);
        chk("pp_idx_held", 32'(bus.frame_idx), 0);
        for (int i = 0; i < 9; i++) begin
            wait_tick(cnt);
            chk($sformatf("pp_period_%0d", i), 32'(cnt), 16);
            chk($sformatf("pp_idx_%0d", i), 32'(bus.frame_idx), 32'(pp_seq[i]));
        end

        for (int i = 0; i < 4; i++) press(4'b0001);
        chk("speed_sat3", 32'(bus.speed), 3);
        wait_tick(cnt);
        chk("fast_period_a", 32'(cnt), 2);
        chk("fast_idx_a", 32'(bus.frame_idx), 2);
        wait_tick(cnt);
        chk("fast_period_b", 32'(cnt), 2);
        chk("fast_idx_b", 32'(bus.frame_idx), 3);
        press(4'b1000);
        chk("run_prev_long_run", 32'(bus.running), 0);
        chk("run_prev_long_idx", 32'(bus.frame_idx), 0);

        press(4'b0100);
        for (int i = 0; i < 3; i++) wait_tick(cnt);
        chk("pre_en_idx", 32'(bus.frame_idx), 3);
        bus.en = 1'b0;
        #1;
        chk("en_low_frame_en", 32'(bus.frame_en), 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.frame_tick) ticks++;
        end
        chk("en_low_running", 32'(bus.running), 0);
        chk("en_low_idx", 32'(bus.frame_idx), 3);
        chk("en_low_ticks", 32'(ticks), 0);
        chk("en_low_frame_en_end", 32'(bus.frame_en), 0);
        bus.en = 1'b1;
        #1;
        chk("en_high_frame_en", 32'(bus.frame_en), 32'b01000);
        step();
        chk("en_high_running", 32'(bus.running), 0);
        chk("en_high_mode", 32'(bus.mode), 1);
        chk("en_high_speed", 32'(bus.speed), 3);

        press(4'b0100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_running", 32'(bus.running), 0);
        chk("midrst_idx", 32'(bus.frame_idx), 0);
        chk("midrst_speed", 32'(bus.speed), 0);
        chk("midrst_mode", 32'(bus.mode), 0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.frame_tick) ticks++;
            step();
        end
        chk("midrst_ticks", 32'(ticks), 0);
        chk("midrst_idx_after", 32'(bus.frame_idx), 0);

        press(4'b0100);
        press(4'b0010);
        chk("speed_sat0", 32'(bus.speed), 0);
        chk("speed_sat0_run", 32'(bus.running), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gif_sequencer.md
GIF_SEQUENCER -- requirements
Module: gif_sequencer

Interface
REQ-001 Parameter FRAMES, default 8: number of frames sequenced, legal range 2..2^IDX_W.
REQ-002 Parameter IDX_W, default 3: width of the frame index.
REQ-003 Parameter BASE_DIV, default 4194304: CLOCK_50 cycles per frame at speed 0; legal range 8..2^26.
REQ-004 Port CLOCK_50  input  1: sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port en  input  1: block enable.
REQ-007 Port next_short  input  1: single-cycle pulse, short press of the "next" key (button_state bit 0).
REQ-008 Port next_long  input  1: single-cycle pulse, long press of the "next" key (button_state bit 1).
REQ-009 Port prev_short  input  1: single-cycle pulse, short press of the "prev" key.
REQ-010 Port prev_long  input  1: single-cycle pulse, long press of the "prev" key.
REQ-011 Port frame_idx  output  IDX_W: current frame number, drives the 8421 frame-indicator LEDs.
REQ-012 Port frame_en  output  FRAMES: one-hot enable to the picture instances.
REQ-013 Port running  output  1: high in the RUN state.
REQ-014 Port mode  output  1: 0 = loop, 1 = ping-pong.
REQ-015 Port speed  output  2: speed level, 0..3.
REQ-016 Port frame_tick  output  1: one-cycle pulse in the cycle after any automatic frame advance.

Function
REQ-017 Two states, MANUAL and RUN; running = (state == RUN); all outputs except frame_en are registered.
REQ-018 frame_en = one-hot decode of frame_idx when en = 1, else all zero; frame_en is combinational from registered frame_idx and en.
REQ-019 Input priority within one cycle: prev_long > next_long > short pulses; a lower-priority pulse arriving in the same cycle as a higher-priority one is discarded.
REQ-020 MANUAL, next_short: frame_idx increments, wrapping from FRAMES-1 to 0.
REQ-021 MANUAL, prev_short: frame_idx decrements, wrapping from 0 to FRAMES-1.
REQ-022 MANUAL, next_short and prev_short in the same cycle: no change.
REQ-023 MANUAL, prev_long: frame_idx = 0; state stays MANUAL.
REQ-024 MANUAL, next_long: go to RUN with timer = 0 and frame_idx held.
REQ-025 RUN timer: counts CLOCK_50 cycles; on reaching PERIOD-1 it resets to 0, frame_idx advances per mode, and frame_tick pulses. PERIOD = BASE_DIV >> speed.
REQ-026 Loop advance: frame_idx+1, wrapping from FRAMES-1 to 0.
REQ-027 Ping-pong advance: an internal dir flag steps frame_idx; dir reverses at each end, so the sequence is 0..FRAMES-1..0 with no endpoint repeated; for FRAMES = 2 it alternates 0,1,0,1.
REQ-028 RUN, next_short: speed+1, saturating at 3; timer cleared.
REQ-029 RUN, prev_short: speed-1, saturating at 0; timer cleared.
REQ-030 RUN, both short pulses in the same cycle: no change.
REQ-031 RUN, next_long: mode toggles; dir = up; timer cleared; frame_idx held.
REQ-032 RUN, prev_long: go to MANUAL with frame_idx = 0, dir = up, timer = 0.
REQ-033 en = 0: forces MANUAL and clears timer and dir; all key inputs are ignored; frame_idx, mode and speed hold; frame_tick = 0.
REQ-034 State and index changes caused by an input are visible the cycle after the pulse; the frame advance happens in the cycle the timer wraps, and frame_tick follows one cycle later.
REQ-035 Timer width is the minimum needed to hold BASE_DIV-1; the timer never exceeds PERIOD-1, including after a speed increase (it is cleared).

Reset
REQ-036 While rst is high at a clock edge, the following take effect at that edge, overriding en and all inputs: frame_idx = 0, state = MANUAL, running = 0, mode = 0, speed = 0, dir = up, timer = 0, frame_tick = 0.
REQ-037 Reset asserted in RUN mid-period aborts the period; after release, the block is in MANUAL and no frame_tick is issued.

Verification (FRAMES=5, IDX_W=3, BASE_DIV=16, en=1 unless stated)
REQ-038 Assert rst for 2 cycles -> frame_idx=0, frame_en=5'b00001, running=0, mode=0, speed=0, frame_tick=0.
REQ-039 From idx 0 apply prev_short -> idx 4, frame_en=5'b10000; then next_short -> idx 0; then next_short and prev_short in the same cycle -> idx stays 0.
REQ-040 Apply next_long, wait 80 cycles -> running=1, frame_tick exactly every 16 cycles, idx sequence 1,2,3,4,0.
REQ-041 In RUN apply next_long (mode=1) from idx 0 -> idx sequence 1,2,3,4,3,2,1,0,1.
REQ-042 In RUN apply next_short x4 -> speed=3, frame_tick every 2 cycles; then prev_long -> running=0 and idx=0 the next cycle.
REQ-043 In RUN deassert en at idx 3 for 10 cycles, then reassert -> frame_en=0 while en is low, running=0, idx remains 3, and no frame_tick is issued.
